// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch buffer: machine word width and queue entry layout.
package fetch_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-side, instruction-memory and decode-side signals of the fetch buffer.
// master is the surrounding pipeline/memory; slave is the buffer itself.
interface fetch_buffer_if;
    import fetch_pkg::*;

    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic            in_ready;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;

    logic            flush;

    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output in_valid, in_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
               flush, out_ready,
        input  in_ready, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, imem_req_ready, imem_resp_valid, imem_resp_data,
               flush, out_ready,
        output in_ready, imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: allocates an entry per issued instruction-memory request,
// fills entries as responses return, and presents filled entries to decode in order.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_buffer_if.slave bus
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    fetch_entry_t     q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] fill;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] discard_cnt;

    logic             has_room;
    logic             push;
    logic             pop;
    logic             resp_take;
    logic             resp_drop;
    logic [CNT_W-1:0] flush_left;

    // Room is judged on registered occupancy only, so a pop never frees a slot in its own cycle.
    assign has_room           = occupancy < FULL;
    assign bus.in_ready       = !rst && !bus.flush && bus.imem_req_ready && has_room;
    assign bus.imem_req_valid = !rst && bus.in_valid && !bus.flush && has_room;
    assign bus.imem_req_addr  = bus.in_pc;

    assign bus.out_valid = !rst && (occupancy != '0) && q[head].filled;
    assign bus.out_pc    = q[head].pc;
    assign bus.out_instr = q[head].instr;

    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = bus.out_valid && bus.out_ready;
    assign resp_drop = bus.imem_resp_valid && (discard_cnt != '0);
    assign resp_take = bus.imem_resp_valid && (discard_cnt == '0) && (pending != '0);

    // Every request still out at memory after a flush must be swallowed, including
    // ones left over from an earlier flush; a response in the flush cycle itself is one of them.
    always_comb begin
        flush_left = discard_cnt + pending;
        if (bus.imem_resp_valid && (flush_left != '0)) begin
            flush_left = flush_left - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            fill        <= '0;
            occupancy   <= '0;
            pending     <= '0;
            discard_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].filled <= 1'b0;
            end
        end else if (bus.flush) begin
            head        <= tail;
            fill        <= tail;
            occupancy   <= '0;
            pending     <= '0;
            discard_cnt <= flush_left;
            for (int i = 0; i < DEPTH; i++) begin
                q[i].filled <= 1'b0;
            end
        end else begin
            if (push) begin
                q[tail].pc     <= bus.in_pc;
                q[tail].filled <= 1'b0;
                tail           <= tail + PTR_W'(1);
            end
            if (resp_take) begin
                q[fill].instr  <= bus.imem_resp_data;
                q[fill].filled <= 1'b1;
                fill           <= fill + PTR_W'(1);
            end
            if (resp_drop) begin
                discard_cnt <= discard_cnt - CNT_W'(1);
            end
            if (pop) begin
                q[head].filled <= 1'b0;
                head           <= head + PTR_W'(1);
            end
            occupancy <= occupancy + CNT_W'(push) - CNT_W'(pop);
            pending   <= pending + CNT_W'(push) - CNT_W'(resp_take);
        end
    end

    // A response with nothing outstanding and nothing to discard is a memory-side protocol error.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && bus.imem_resp_valid && (discard_cnt == '0)) begin
            assert (pending != '0);
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: an in-order memory model with random latency feeds
// the buffer, and a monitor checks the decode stream against the accepted-PC queue.
module tb_fetch_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          issue;
    } mem_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_buffer_if bus ();

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          n_chk         = 0;
    int          n_pass        = 0;
    int          cyc           = 0;
    int          resp_pct      = 100;
    int          accepted      = 0;
    bit          clear_pending = 1'b0;
    bit          force_en      = 1'b0;
    logic [31:0] force_data    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    endtask

    // One clock: drive inputs after the edge, play the memory, then record the handshakes.
    task automatic cycle(input logic r, input logic v, input logic [31:0] pc,
                         input logic rr, input logic fl, input logic ordy);
        exp_t e;
        mem_t m;
        logic exp_ready;
        logic exp_req;
        @(posedge clk);
        if (clear_pending) begin
            exp_q.delete();
            clear_pending = 1'b0;
        end
        cyc++;
        #1;
        rst                 = r;
        bus.in_valid        = v;
        bus.in_pc           = pc;
        bus.imem_req_ready  = rr;
        bus.flush           = fl;
        bus.out_ready       = ordy;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom();
        if (!r && mem_q.size() > 0 && mem_q[0].issue < cyc && $urandom_range(99) < resp_pct) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_q[0].data;
        end
        exp_ready = !fl && rr && (exp_q.size() < DEPTH);
        exp_req   = v && !fl && (exp_q.size() < DEPTH);
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            mem_q.delete();
            clear_pending = 1'b0;
        end else begin
            check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            if (bus.imem_resp_valid) void'(mem_q.pop_front());
            if (v && exp_ready) begin
                e.pc    = pc;
                e.instr = force_en ? force_data : $urandom();
                m.data  = e.instr;
                m.issue = cyc;
                exp_q.push_back(e);
                mem_q.push_back(m);
                accepted++;
            end
            if (fl) clear_pending = 1'b1;
        end
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, ordy);
    endtask

    task automatic drain();
        resp_pct = 100;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || mem_q.size() != 0); i++) idle(1'b1);
        idle(1'b1);
        check("drain_model_empty", 32'(exp_q.size()), 32'd0);
        check("drain_occupancy", 32'(dut.occupancy), 32'd0);
    endtask

    // Monitor: compares every consumed head against the scoreboard and checks stall stability.
    initial begin
        bit          stalled = 1'b0;
        logic [31:0] s_pc    = '0;
        logic [31:0] s_instr = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    check("stall_out_pc", bus.out_pc, s_pc);
                    check("stall_out_instr", bus.out_instr, s_instr);
                end
                if (bus.out_valid && bus.out_ready) begin
                    check("output_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_pc", bus.out_pc, e.pc);
                        check("out_instr", bus.out_instr, e.instr);
                    end
                end
                if (bus.imem_req_valid) check("imem_req_addr", bus.imem_req_addr, bus.in_pc);
                stalled = bus.out_valid && !bus.out_ready && !bus.flush;
                s_pc    = bus.out_pc;
                s_instr = bus.out_instr;
            end
        end
    end

    initial begin
        bit got;
        bus.in_valid        = 1'b0;
        bus.in_pc           = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.flush           = 1'b0;
        bus.out_ready       = 1'b0;

        // Reset: outputs held low even with a request presented.
        cycle(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_imem_req_valid", 32'(bus.imem_req_valid), 32'd0);
        cycle(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        check("post_rst_occupancy", 32'(dut.occupancy), 32'd0);
        check("post_rst_discard", 32'(dut.discard_cnt), 32'd0);
        check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Streaming with one-cycle memory latency.
        resp_pct = 100;
        cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b1);
        check("stream_no_out_yet", 32'(bus.out_valid), 32'd0);
        cycle(1'b0, 1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
        check("stream_valid0", 32'(bus.out_valid), 32'd1);
        check("stream_pc0", bus.out_pc, 32'h0);
        idle(1'b1);
        check("stream_valid1", 32'(bus.out_valid), 32'd1);
        check("stream_pc1", bus.out_pc, 32'h4);
        idle(1'b1);
        check("stream_valid2", 32'(bus.out_valid), 32'd1);
        check("stream_pc2", bus.out_pc, 32'h8);
        idle(1'b1);
        check("stream_done", 32'(bus.out_valid), 32'd0);

        // Full: four accepts with decode stalled, then one pop frees a slot a cycle later.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            check("full_accept", 32'(bus.in_ready), 32'd1);
        end
        cycle(1'b0, 1'b1, 32'h210, 1'b1, 1'b0, 1'b0);
        check("full_in_ready_low", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, 1'b1, 32'h210, 1'b1, 1'b0, 1'b1);
        check("full_pop_cycle_no_credit", 32'(bus.in_ready), 32'd0);
        check("full_pop_valid", 32'(bus.out_valid), 32'd1);
        cycle(1'b0, 1'b1, 32'h210, 1'b1, 1'b0, 1'b0);
        check("full_in_ready_back", 32'(bus.in_ready), 32'd1);
        drain();

        // Flush with three requests outstanding at memory.
        resp_pct = 0;
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h304, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h308, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        check("flush3_discard", 32'(dut.discard_cnt), 32'd3);
        check("flush3_occupancy", 32'(dut.occupancy), 32'd0);
        check("flush3_out_valid", 32'(bus.out_valid), 32'd0);
        resp_pct = 100;
        repeat (4) idle(1'b1);
        check("flush3_discard_done", 32'(dut.discard_cnt), 32'd0);
        force_en   = 1'b1;
        force_data = 32'hDEADBEEF;
        cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0);
        force_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            idle(1'b0);
            got = bus.out_valid;
        end
        check("flush3_wait_out", 32'(got), 32'd1);
        check("flush3_out_pc", bus.out_pc, 32'h100);
        check("flush3_out_instr", bus.out_instr, 32'hDEADBEEF);
        drain();

        // Flush with a response landing in the flush cycle itself.
        resp_pct = 0;
        cycle(1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h504, 1'b1, 1'b0, 1'b1);
        resp_pct = 100;
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        check("flushresp_resp_seen", 32'(bus.imem_resp_valid), 32'd1);
        resp_pct = 0;
        idle(1'b1);
        check("flushresp_discard", 32'(dut.discard_cnt), 32'd1);
        check("flushresp_out_valid", 32'(bus.out_valid), 32'd0);
        resp_pct = 100;
        repeat (2) idle(1'b1);
        check("flushresp_discard_done", 32'(dut.discard_cnt), 32'd0);
        check("flushresp_no_out", 32'(bus.out_valid), 32'd0);
        drain();

        // Reset with two filled entries and one request in flight.
        resp_pct = 100;
        cycle(1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 32'h604, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        resp_pct = 0;
        cycle(1'b0, 1'b1, 32'h608, 1'b1, 1'b0, 1'b0);
        check("midrst_out_valid_before", 32'(bus.out_valid), 32'd1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_occupancy", 32'(dut.occupancy), 32'd0);
        check("midrst_discard", 32'(dut.discard_cnt), 32'd0);

        // Random backpressure over 100 accepted PCs, no flush.
        accepted = 0;
        resp_pct = 60;
        for (int i = 0; i < 3000 && accepted < 100; i++) begin
            cycle(1'b0, $urandom_range(99) < 70, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(99) < 80, 1'b0, $urandom_range(1));
        end
        check("random_accepted", 32'(accepted), 32'd100);
        drain();

        // Random traffic with occasional redirects.
        resp_pct = 60;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, $urandom_range(99) < 70, $urandom() & 32'hFFFF_FFFC,
                  $urandom_range(99) < 80,
                  ($urandom_range(99) < 5) && (mem_q.size() <= 2 * DEPTH - 1),
                  $urandom_range(1));
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of buffer entries, including in-flight ones; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the fetch stage presents a PC.
REQ-005 SHALL have port in_pc, input, 32 bits: the PC to fetch.
REQ-006 SHALL have port in_ready, output, 1 bit: the buffer accepts in_pc this cycle.
REQ-007 SHALL have port imem_req_valid, output, 1 bit: instruction-memory request.
REQ-008 SHALL have port imem_req_addr, output, 32 bits: request address, equal to in_pc.
REQ-009 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-010 SHALL have port imem_resp_valid, input, 1 bit: response beat; responses return in request order.
REQ-011 SHALL have port imem_resp_data, input, 32 bits: instruction word.
REQ-012 SHALL have port flush, input, 1 bit: redirect; discard all buffered and in-flight work.
REQ-013 SHALL have port out_valid, output, 1 bit: the head entry is filled and presented to decode.
REQ-014 SHALL have port out_pc, output, 32 bits: PC of the head entry.
REQ-015 SHALL have port out_instr, output, 32 bits: instruction of the head entry.
REQ-016 SHALL have port out_ready, input, 1 bit: decode consumes the head.

Function
REQ-017 SHALL keep a circular queue of DEPTH entries with head, tail and fill pointers; each entry holds pc, instr and a filled bit.
REQ-018 SHALL drive in_ready = !flush && imem_req_ready && (occupancy < DEPTH); occupancy counts allocated entries, filled or not, and is taken from registered state only (no same-cycle credit from a pop).
REQ-019 SHALL drive imem_req_valid = in_valid && !flush && (occupancy < DEPTH), and imem_req_addr = in_pc.
REQ-020 On in_valid && in_ready, SHALL allocate the tail entry with pc = in_pc and filled = 0, then advance tail modulo DEPTH.
REQ-021 On an accepted imem_resp_valid (not discarded), SHALL write imem_resp_data into the entry at the fill pointer, set filled, and advance fill modulo DEPTH.
REQ-022 SHALL drive out_valid = head entry allocated and filled; out_pc and out_instr come from registers; there is no combinational path from imem_resp_* to out_*. Minimum latency: response at cycle t, out_valid at t+1.
REQ-023 On out_valid && out_ready, SHALL free the head entry and advance head; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-024 SHALL hold out_pc and out_instr stable while out_valid && !out_ready.
REQ-025 On flush, SHALL, by the next cycle, empty the queue (head = tail = fill, occupancy 0, out_valid 0), and set discard_cnt to the number of allocated-but-unfilled entries, minus one if a response arrives in the flush cycle.
REQ-026 While discard_cnt > 0, SHALL drop each arriving response without writing it and decrement discard_cnt; new requests are still allowed and count against occupancy.
REQ-027 A response arriving in the same cycle as flush SHALL be dropped.
REQ-028 A response with no outstanding request and discard_cnt = 0 is illegal; the buffer SHALL flag it with a simulation assertion and ignore it.
REQ-029 Pointers SHALL be log2(DEPTH) bits with natural wrap; occupancy and discard_cnt SHALL be log2(DEPTH)+1 bits.

Reset
REQ-030 On rst, SHALL clear head, tail, fill, occupancy, discard_cnt and all filled bits; the outputs SHALL read out_valid = 0, in_ready = 0 during reset, and imem_req_valid = 0.
REQ-031 rst SHALL take priority over flush, push, pop and response; reset in the middle of a transaction drops in-flight responses, and the memory is reset alongside.
REQ-032 Entry pc and instr fields need no reset; out_pc and out_instr are don't-care while out_valid = 0.

Structure
REQ-033 SHALL take XLEN = 32 and the fetch_entry_t typedef (pc, instr, filled) from the shared package fetch_pkg.
REQ-034 SHALL be a single module with no sub-modules; the queue is an array of fetch_entry_t.

Verification
REQ-035 Streaming: PCs 0x0, 0x4, 0x8 with 1-cycle memory latency and out_ready = 1 SHALL produce out_pc 0x0, 0x4, 0x8 with matching data, one per cycle after fill.
REQ-036 Full: out_ready = 0 with DEPTH = 4 SHALL make in_ready drop after 4 accepts; one pop SHALL let in_ready rise the next cycle.
REQ-037 Flush with 3 in flight: assert flush, then return 3 responses, then PC 0x100 returning 0xDEADBEEF SHALL yield only out_pc 0x100 with out_instr 0xDEADBEEF.
REQ-038 Flush-cycle response: flush with 2 in flight, one response in the flush cycle, SHALL give discard_cnt = 1 and no output from either response.
REQ-039 Backpressure: out_ready toggling 0/1 SHALL keep out_pc and out_instr stable while stalled, with no loss or duplication over 100 random PCs.
REQ-040 Reset mid-stream: rst with 2 buffered and 1 in flight SHALL give out_valid = 0 and occupancy 0 the next cycle.
